// File: rtl/reg_writeback_sequencer_if.sv
// Writeback bus between the execute stage, the sequencer and the GPR blocks.
// The sequencer sits on the slave modport; the execute/observer side uses master.
interface reg_writeback_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_dst0;
    logic [DATA_W-1:0] in_data0;
    logic [3:0]        in_dst1;
    logic [DATA_W-1:0] in_data1;
    logic [3:0]        rf_sel;
    logic [DATA_W-1:0] rf_data;
    logic [CW-1:0]     count;
    logic              busy;
    logic              drop_err;

    modport master (
        output in_valid, in_dst0, in_data0, in_dst1, in_data1,
        input  in_ready, rf_sel, rf_data, count, busy, drop_err
    );

    modport slave (
        input  in_valid, in_dst0, in_data0, in_dst1, in_data1,
        output in_ready, rf_sel, rf_data, count, busy, drop_err
    );
endinterface

// File: rtl/reg_writeback_sequencer.sv
// Buffers execute results and serializes up to two GPR writes per result onto
// the shared rf_sel/rf_data bus, one-clock write pulses separated by idle clocks.
module reg_writeback_sequencer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    reg_writeback_sequencer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, WR0, SEP, WR1} state_t;

    logic [3:0]        r_mem_dst0  [DEPTH];
    logic [DATA_W-1:0] r_mem_data0 [DEPTH];
    logic [3:0]        r_mem_dst1  [DEPTH];
    logic [DATA_W-1:0] r_mem_data1 [DEPTH];

    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_drop_err;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [3:0]        r_hold_dst1;
    logic [DATA_W-1:0] r_hold_data1;

    logic [3:0]        r_rf_sel;
    logic [DATA_W-1:0] r_rf_data;

    logic              w_in_ready;
    logic              w_push;
    logic              w_pop;
    logic [3:0]        w_sel_nxt;
    logic [DATA_W-1:0] w_data_nxt;

    logic [3:0]        w_head_dst0;
    logic [DATA_W-1:0] w_head_data0;
    logic [3:0]        w_head_dst1;
    logic [DATA_W-1:0] w_head_data1;

    // in_ready depends only on the registered occupancy, never on this cycle's pop
    assign w_in_ready   = (r_count < CW'(DEPTH));
    assign w_push       = bus.in_valid && w_in_ready;

    assign w_head_dst0  = r_mem_dst0[r_rd_ptr];
    assign w_head_data0 = r_mem_data0[r_rd_ptr];
    assign w_head_dst1  = r_mem_dst1[r_rd_ptr];
    assign w_head_data1 = r_mem_data1[r_rd_ptr];

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem_dst0[r_wr_ptr]  <= bus.in_dst0;
            r_mem_data0[r_wr_ptr] <= bus.in_data0;
            r_mem_dst1[r_wr_ptr]  <= bus.in_dst1;
            r_mem_data1[r_wr_ptr] <= bus.in_data1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_drop_err <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (bus.in_valid && !w_in_ready) r_drop_err <= 1'b1;
        end
    end

    // Second destination is parked here so the head slot can be refilled
    always_ff @(posedge clock) begin
        if (w_pop) begin
            r_hold_dst1  <= w_head_dst1;
            r_hold_data1 <= w_head_data1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (r_count != '0) begin
                    if (w_head_dst0 != 4'h0 && w_head_dst0 != w_head_dst1) w_state_nxt = WR0;
                    else if (w_head_dst1 != 4'h0)                           w_state_nxt = WR1;
                end
            end
            WR0:     w_state_nxt = (r_hold_dst1 != 4'h0) ? SEP : IDLE;
            SEP:     w_state_nxt = WR1;
            WR1:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // A duplicate destination falls through to the dst1 write only
    always_comb begin
        w_pop      = 1'b0;
        w_sel_nxt  = 4'h0;
        w_data_nxt = r_rf_data;
        unique case (r_state)
            IDLE: begin
                if (r_count != '0) begin
                    w_pop = 1'b1;
                    if (w_head_dst0 != 4'h0 && w_head_dst0 != w_head_dst1) begin
                        w_sel_nxt  = w_head_dst0;
                        w_data_nxt = w_head_data0;
                    end else if (w_head_dst1 != 4'h0) begin
                        w_sel_nxt  = w_head_dst1;
                        w_data_nxt = w_head_data1;
                    end
                end
            end
            SEP: begin
                w_sel_nxt  = r_hold_dst1;
                w_data_nxt = r_hold_data1;
            end
            default: begin
                w_sel_nxt  = 4'h0;
                w_data_nxt = r_rf_data;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rf_sel  <= 4'h0;
            r_rf_data <= '0;
        end else begin
            r_rf_sel  <= w_sel_nxt;
            r_rf_data <= w_data_nxt;
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.rf_sel   = r_rf_sel;
    assign bus.rf_data  = r_rf_data;
    assign bus.count    = r_count;
    assign bus.busy     = (r_state != IDLE) || (r_count != '0);
    assign bus.drop_err = r_drop_err;

endmodule

// File: tb/tb_reg_writeback_sequencer.sv
// Directed bench for reg_writeback_sequencer: single, dual, duplicate, null,
// full/drop, pointer wrap and mid-operation reset.
module tb_reg_writeback_sequencer;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    reg_writeback_sequencer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    reg_writeback_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    logic [35:0] obs_q[$];
    int          pulse_err = 0;
    logic [3:0]  prev_sel  = 4'h0;

    // Record every write pulse and flag any two nonzero selects in a row
    always @(negedge clock) begin
        if (bus.rf_sel != 4'h0) begin
            obs_q.push_back({bus.rf_sel, bus.rf_data});
            if (prev_sel != 4'h0) pulse_err++;
        end
        prev_sel = bus.rf_sel;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] d0, input logic [31:0] x0,
                         input logic [3:0] d1, input logic [31:0] x1);
        bus.in_valid = v;
        bus.in_dst0  = d0;
        bus.in_data0 = x0;
        bus.in_dst1  = d1;
        bus.in_data1 = x1;
    endtask

    task automatic drain();
        for (int c = 0; c < 60 && bus.busy; c++) tick();
    endtask

    logic [3:0]  ed0 [6] = '{4'h1, 4'h3, 4'h5, 4'h7, 4'h2, 4'h8};
    logic [3:0]  ed1 [6] = '{4'h2, 4'h4, 4'h6, 4'h8, 4'h7, 4'h1};
    int          snap;

    initial begin
        drive(1'b0, 4'h0, 32'h0, 4'h0, 32'h0);
        tick(); tick();
        reset = 1'b0;
        chk("rst_sel",    bus.rf_sel,   0);
        chk("rst_data",   bus.rf_data,  0);
        chk("rst_count",  bus.count,    0);
        chk("rst_ready",  bus.in_ready, 1);
        chk("rst_busy",   bus.busy,     0);
        chk("rst_drop",   bus.drop_err, 0);

        // single write to EDI
        drive(1'b1, 4'h6, 32'h0000_0888, 4'h0, 32'h0);
        tick();
        drive(1'b0, 4'h0, 32'h0, 4'h0, 32'h0);
        chk("single_count", bus.count, 1);
        chk("single_sel_k", bus.rf_sel, 0);
        tick();
        chk("single_sel",  bus.rf_sel,  4'h6);
        chk("single_data", bus.rf_data, 32'h0000_0888);
        tick();
        chk("single_sel_off", bus.rf_sel,  0);
        chk("single_busy",    bus.busy,    0);
        chk("single_hold",    bus.rf_data, 32'h0000_0888);

        // dual write ESI then EDI
        drive(1'b1, 4'h5, 32'h1111_1111, 4'h6, 32'h2222_2222);
        tick();
        drive(1'b0, 4'h0, 32'h0, 4'h0, 32'h0);
        tick();
        chk("dual_w0", {bus.rf_sel, bus.rf_data}, {4'h5, 32'h1111_1111});
        tick();
        chk("dual_sep", {bus.rf_sel, bus.rf_data}, {4'h0, 32'h1111_1111});
        tick();
        chk("dual_w1", {bus.rf_sel, bus.rf_data}, {4'h6, 32'h2222_2222});
        tick();
        chk("dual_end", {bus.rf_sel, bus.busy}, {4'h0, 1'b0});

        // duplicate destination: only the dst1 write
        drive(1'b1, 4'h6, 32'hAAAA_AAAA, 4'h6, 32'hBBBB_BBBB);
        tick();
        drive(1'b0, 4'h0, 32'h0, 4'h0, 32'h0);
        tick();
        chk("dup_w", {bus.rf_sel, bus.rf_data}, {4'h6, 32'hBBBB_BBBB});
        tick();
        chk("dup_end", {bus.rf_sel, bus.busy}, {4'h0, 1'b0});

        // null entry: consumed without a write
        obs_q.delete();
        drive(1'b1, 4'h0, 32'h1234_5678, 4'h0, 32'h9ABC_DEF0);
        tick();
        drive(1'b0, 4'h0, 32'h0, 4'h0, 32'h0);
        chk("null_count1", bus.count, 1);
        tick();
        chk("null_count0", bus.count,   0);
        chk("null_busy",   bus.busy,    0);
        chk("null_hold",   bus.rf_data, 32'hBBBB_BBBB);
        tick();
        chk("null_nowrite", obs_q.size(), 0);

        // six back-to-back dual offers: five accepted, the sixth dropped
        obs_q.delete();
        pulse_err = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, ed0[i], 32'hA000_0000 + i, ed1[i], 32'hB000_0000 + i);
            tick();
            if (i == 4) begin
                chk("full_ready", bus.in_ready, 0);
                chk("full_count", bus.count,    4);
                chk("full_nodrop", bus.drop_err, 0);
            end
        end
        drive(1'b0, 4'h0, 32'h0, 4'h0, 32'h0);
        chk("drop_set",    bus.drop_err, 1);
        chk("drop_count",  bus.count,    3);
        chk("drop_ready",  bus.in_ready, 1);
        drain();
        tick();
        chk("full_idle",   bus.busy,     0);
        chk("full_nwrite", obs_q.size(), 10);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("full_e%0d_w0", i), (obs_q.size() > 2*i)   ? obs_q[2*i]   : 36'h0,
                {ed0[i], 32'hA000_0000 + i});
            chk($sformatf("full_e%0d_w1", i), (obs_q.size() > 2*i+1) ? obs_q[2*i+1] : 36'h0,
                {ed1[i], 32'hB000_0000 + i});
        end
        chk("full_pulse", pulse_err, 0);
        chk("drop_sticky", bus.drop_err, 1);

        // pointer wrap with single-destination entries
        obs_q.delete();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'(i + 1), 32'hC000_0000 + i, 4'h0, 32'h0);
            tick();
        end
        drive(1'b0, 4'h0, 32'h0, 4'h0, 32'h0);
        drain();
        tick();
        chk("wrap_nwrite", obs_q.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("wrap_w%0d", i), (obs_q.size() > i) ? obs_q[i] : 36'h0,
                {4'(i + 1), 32'hC000_0000 + i});
        chk("wrap_pulse", pulse_err, 0);

        // reset while in SEP with two entries queued
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'(2*i + 1), 32'hD000_0000 + i, 4'(2*i + 2), 32'hE000_0000 + i);
            tick();
        end
        drive(1'b0, 4'h0, 32'h0, 4'h0, 32'h0);
        chk("mid_count", bus.count,  2);
        chk("mid_sel",   bus.rf_sel, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        snap = obs_q.size();
        chk("mid_rst_sel",   bus.rf_sel,   0);
        chk("mid_rst_count", bus.count,    0);
        chk("mid_rst_drop",  bus.drop_err, 0);
        chk("mid_rst_busy",  bus.busy,     0);
        for (int c = 0; c < 10; c++) tick();
        chk("mid_nowrite", obs_q.size(), snap);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
